// File: rtl/load_return_align_pkg.sv
// Shared types for the load return path: FSM state encoding and access size codes.
package load_return_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Byte wins over halfword; no size flag set means a word access.
  function automatic size_t size_decode(input logic mb, input logic mh);
    if (mb)      return SZ_B;
    else if (mh) return SZ_H;
    else         return SZ_W;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select plus sign/zero extension of a 32-bit memory word for byte/half/word loads.
module load_extract
  import load_return_align_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    data   = word;
    case (size)
      SZ_B:    data = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H:    data = {{16{sgn & half_v[15]}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_return_align.sv
// MEM->WB load return path: waits for the memory word, aligns/extends it, holds it for WB.
// Optional macro LOAD_ADEL_EN adds misaligned-address reporting (wb_adel, wb_badvaddr).
module load_return_align
  import load_return_align_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_mb,
  input  logic        req_mh,
  input  logic        req_mw,
  input  logic        req_signed,
  input  logic        rdata_valid,
  input  logic [31:0] rdata,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        stall,
`ifdef LOAD_ADEL_EN
  output logic        wb_adel,
  output logic [31:0] wb_badvaddr,
`endif
  output logic        bus_err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [1:0]    lane;
  size_t         size;
  logic          sgn;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          timeout_hit;
  logic [31:0]   ext_data;
  size_t         req_size;

  assign req_ready   = (state == IDLE) || ((state == HOLD) && wb_ready);
  assign accept      = req_valid && req_ready && !flush;
  assign stall       = (state == WAIT) || (state == DRAIN) || ((state == HOLD) && !wb_ready);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
  assign req_size    = size_decode(req_mb, req_mh);

`ifdef LOAD_ADEL_EN
  logic misaligned;
  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  logic unused_mw;
  assign unused_mw = req_mw;
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:2], req_mw};
`endif

  load_extract u_extract (
    .word (rdata),
    .lane (lane),
    .size (size),
    .sgn  (sgn),
    .data (ext_data)
  );

  // Transaction FSM; a same-cycle accept overrides the HOLD->IDLE exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      lane        <= 2'b00;
      size        <= SZ_B;
      sgn         <= 1'b0;
      cnt         <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      bus_err     <= 1'b0;
`ifdef LOAD_ADEL_EN
      wb_adel     <= 1'b0;
      wb_badvaddr <= '0;
`endif
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: ;
        WAIT: begin
          if (flush) begin
            state <= rdata_valid ? IDLE : DRAIN;
            cnt   <= cnt + CW'(1);
          end else if (rdata_valid) begin
            wb_data  <= ext_data;
            wb_valid <= 1'b1;
            state    <= HOLD;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (flush || wb_ready) begin
            wb_valid <= 1'b0;
`ifdef LOAD_ADEL_EN
            wb_adel  <= 1'b0;
`endif
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (rdata_valid) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        lane  <= req_addr[1:0];
        size  <= req_size;
        sgn   <= req_signed;
        cnt   <= '0;
        state <= WAIT;
`ifdef LOAD_ADEL_EN
        // Misaligned access: report immediately, no memory response expected.
        if (misaligned) begin
          state       <= HOLD;
          wb_valid    <= 1'b1;
          wb_adel     <= 1'b1;
          wb_badvaddr <= req_addr;
          wb_data     <= '0;
        end
`endif
      end
    end
  end

endmodule
